// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to main_mem and buffers
// responses in a two-entry {inst, pc} queue toward decode; redirects flush everything.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_ready,
    output logic        o_im_ren,
    output logic [13:0] o_im_addr,
    input  logic [31:0] i_im_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    input  logic        i_ready
);

    logic [31:0] pc;
    logic        inflight;
    logic [31:0] inflight_pc;
    logic [1:0]  count;
    logic [31:0] head_inst;
    logic [31:0] head_pc;
    logic [31:0] tail_inst;
    logic [31:0] tail_pc;

    logic        pop;
    logic        push;
    logic        accept;
    logic [2:0]  occupancy;
    logic [1:0]  wr_slot;
    logic [1:0]  count_next;
    logic [31:0] head_inst_next;
    logic [31:0] head_pc_next;
    logic [31:0] tail_inst_next;
    logic [31:0] tail_pc_next;
    logic [31:0] redirect_target;
    logic        unused_redirect_bits;

    assign o_valid   = (count != 2'd0);
    assign o_inst    = head_inst;
    assign o_pc      = head_pc;
    assign o_im_addr = pc[15:2];

    assign pop  = o_valid && i_ready;
    assign push = inflight;

    // Slots committed after this cycle's pop; the in-flight word already owns one.
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign o_im_ren  = !i_rst && !i_redirect && (occupancy < 3'd2);
    assign accept    = o_im_ren && i_mem_ready;

    assign redirect_target      = {i_redirect_pc[31:2], 2'b00};
    assign unused_redirect_bits = ^i_redirect_pc[1:0];

    assign wr_slot    = count - {1'b0, pop};
    assign count_next = count + {1'b0, push} - {1'b0, pop};

    always_comb begin
        head_inst_next = head_inst;
        head_pc_next   = head_pc;
        tail_inst_next = tail_inst;
        tail_pc_next   = tail_pc;
        if (pop) begin
            head_inst_next = tail_inst;
            head_pc_next   = tail_pc;
        end
        if (push) begin
            if (wr_slot == 2'd0) begin
                head_inst_next = i_im_rdata;
                head_pc_next   = inflight_pc;
            end else begin
                tail_inst_next = i_im_rdata;
                tail_pc_next   = inflight_pc;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            count       <= 2'd0;
            head_inst   <= 32'h0;
            head_pc     <= 32'h0;
            tail_inst   <= 32'h0;
            tail_pc     <= 32'h0;
        end else if (i_redirect) begin
            // Response landing next cycle belongs to the old stream and is dropped.
            pc       <= redirect_target;
            inflight <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (accept) begin
                pc          <= pc + 32'd4;
                inflight_pc <= pc;
            end
            inflight  <= accept;
            count     <= count_next;
            head_inst <= head_inst_next;
            head_pc   <= head_pc_next;
            tail_inst <= tail_inst_next;
            tail_pc   <= tail_pc_next;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the funRV32 core. Owns the program counter, issues word reads on the instruction port of `main_mem`, absorbs its one-cycle registered read latency and its `o_ready` stalls, and presents fetched instructions with their PC to decode over a valid/ready handshake. Branch and jump redirects from execute flush all buffered and in-flight fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: byte PC loaded on reset; bits [1:0] must be 0.
- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_mem_ready`  in  1  `main_mem` `o_ready`; a read is accepted only while high.
- `o_im_ren`  out  1  fetch request to `main_mem`.
- `o_im_addr`  out  14  word address, equal to `pc[15:2]`.
- `i_im_rdata`  in  32  read data, valid the cycle after an accepted request.
- `i_redirect`  in  1  one-cycle pulse: flush and restart at `i_redirect_pc`.
- `i_redirect_pc`  in  32  new byte PC; bits [1:0] are ignored and treated as 0.
- `o_valid`  out  1  `o_inst`/`o_pc` hold a fetched instruction.
- `o_inst`  out  32  instruction word.
- `o_pc`  out  32  byte PC of `o_inst`.
- `i_ready`  in  1  decode accepts. Transfer occurs when `o_valid && i_ready`.

## Operation
- State:
  - `pc`: 32-bit next fetch address.
  - `inflight`: 1 bit, plus the PC of the in-flight request.
  - Output FIFO: 2 entries of {inst, pc}, with `count` from 0 to 2.
- `pop` = `o_valid && i_ready`.
- Issue condition: `o_im_ren = !i_rst && !i_redirect && (count + inflight - pop) < 2`.
  - A request is accepted when `o_im_ren && i_mem_ready`.
  - On accept: `pc <= pc + 4` (wraps mod 2^32), `inflight <= 1`, and the in-flight PC is latched.
  - If the request is not accepted, `inflight <= 0` and `pc` holds.
- Response: when `inflight` is 1, `i_im_rdata` plus the latched PC is pushed into the FIFO that cycle.
  - Push and pop in the same cycle are legal; `count` is unchanged.
  - The issue rule guarantees a push never hits a full FIFO. Verification asserts this.
- `o_im_addr` always equals `pc[15:2]`, even while `o_im_ren` is low. It aliases every 64 KiB.
- `o_valid = (count != 0)`. `o_inst`/`o_pc` show the FIFO head and stay stable while `o_valid && !i_ready`.
- Redirect (`i_redirect` high) has priority over every other event that cycle:
  - `pc <= {i_redirect_pc[31:2], 2'b00}`.
  - FIFO cleared: `count <= 0`.
  - `inflight <= 0`, so response data arriving next cycle is discarded.
  - No request is issued.
  - If `pop` is also high, decode has taken the head; the flush still applies.
- No FSM beyond the above. Two modes follow from state:
  - STREAM: issuing each cycle.
  - STALL: FIFO full or `i_mem_ready` low.
- A stall on `i_mem_ready` never drops or duplicates a PC.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `pc = RESET_PC`, `inflight = 0`, `count = 0`.
  - `o_valid = 0`, `o_im_ren = 0`.
  - `o_inst`/`o_pc` are don't-care while `o_valid = 0`.
- Reset mid-operation discards in-flight and buffered fetches immediately.
- First request: first cycle after reset release with `i_mem_ready = 1`. Call it cycle 0.
  - Data arrives at cycle 1.
  - `o_valid = 1` at cycle 2.
- Fetch-to-valid latency is 2 cycles. With `i_ready` held high, throughput is 1 instruction/cycle.
- Redirect in cycle R:
  - First new request in R+1.
  - `o_valid` for the target instruction in R+3 at the earliest.
  - `o_valid` is 0 in R+1 and R+2.
- Memory stall: while `i_mem_ready = 0`, no request is accepted. Any already in-flight data is still pushed.
- Backpressure: with `i_ready` held low, at most 2 requests are outstanding (FIFO plus in-flight), and `o_im_ren` drops.

## Test plan
- Reset with `RESET_PC = 0`, `i_ready = 1`, `i_mem_ready = 1`, memory word k = k+0x100 -> `o_valid` rises 2 cycles after release. Then `o_pc` = 0, 4, 8, ... and `o_inst` = 0x100, 0x101, ..., one per cycle.
- Hold `i_ready = 0` for 10 cycles mid-stream -> `o_im_ren` goes low once `count + inflight = 2`. `o_inst`/`o_pc` stay stable. On release the sequence continues with no gaps or duplicates.
- Drive `i_mem_ready = 0` for 3 cycles -> `pc` holds and no PC is skipped or repeated. The instruction that was in-flight when the stall began is still delivered.
- `i_redirect = 1`, `i_redirect_pc = 0x0000_0043` while the FIFO is full and a request is in flight -> `o_valid = 0` for 2 cycles. The next transfer has `o_pc = 0x40` and `o_inst` = word 0x10.
- `i_redirect` in the same cycle as a `pop` -> head consumed, remainder flushed, next `o_pc` = redirect target.
- Assert `i_rst` asynchronously mid-stream -> `o_valid` and `o_im_ren` drop in the same cycle. After release, fetch restarts at `RESET_PC`.
